decoder_scan_ctrl: RTL and testbench
====================================

Name: decoder_scan_ctrl

Overview:
Sequencer that sits directly upstream of the 3-to-8 decoder and drives the decoder's enable and 3-bit select inputs. It steps through the enabled output positions in ascending order, holding each for a programmable dwell time, with optional blanking gaps between positions. It supports single-pass and continuous scanning and is used for LED/digit multiplexing and row scanning.

Parameters:
DWELL, 4, clock cycles E is held high per code (legal range 1..255)
BLANK, 1, clock cycles E is held low between consecutive codes (legal range 0..255; 0 means no gap)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a scan; ignored while busy=1
stop  input  1  synchronous abort; takes priority over all other activity
cont  input  1  1 = continuous scan, 0 = single pass; sampled with start
mask  input  8  bit i=1 includes code i in the scan; sampled with start
E  output  1  decoder enable, registered
Code  output  3  decoder select, registered; feeds decoder In
busy  output  1  high from the cycle after an accepted start until the return to IDLE
done  output  1  one-cycle pulse when a single pass completes

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset, asserted at any time, immediately forces: E=0, Code=0, busy=0, done=0, state=IDLE, counters=0, captured mask=0, captured cont=0.
- States: IDLE, ACTIVE, GAP.
- IDLE: at an edge with start=1, stop=0 and mask!=0, capture mask and cont, load Code with the lowest set mask index, and move to ACTIVE. From the next cycle, E=1 and busy=1.
  - start with mask==0: ignored, no state change, no done.
- ACTIVE: E=1 for exactly DWELL cycles, then select the next code, defined as the lowest set captured-mask index strictly greater than Code.
  - If a next code exists: go to GAP if BLANK>0 (E=0, Code held), else go straight to ACTIVE with the new Code so E stays high.
  - If no next code exists (end of pass):
    - cont=1: wrap to the lowest set index, via GAP when BLANK>0.
    - cont=0: go to GAP if BLANK>0, otherwise go to IDLE directly.
- GAP: E=0 for exactly BLANK cycles. Code is updated to the next code on entry to the following ACTIVE, not during GAP.
  - At the end of the final GAP of a single pass, go to IDLE.
- End of single pass:
  - On the transition to IDLE, done=1 for one cycle and busy=0 in that same cycle.
  - Code holds its last value and E=0.
- Single-bit mask with cont=1: the same code repeats, with a GAP between dwells when BLANK>0 and E held continuously high when BLANK=0.
- Changes to mask or cont while busy: ignored; the captured copies are used.
- start while busy: ignored.
- stop:
  - At the next edge, go to IDLE with E=0, busy=0, Code held and no done pulse.
  - stop and start asserted together in IDLE: stop wins and the scan does not start.
- E is never high while busy=0.
- Code changes only while E=0 or on an ACTIVE-to-ACTIVE transition (BLANK=0); no glitches reach the decoder.
- Counters: 8-bit dwell/gap counter that reloads on every state entry. The next-index search is combinational priority logic over the captured mask.
- Single-pass duration: N*(DWELL+BLANK) busy cycles, where N = popcount(mask).

Test Plan:
- Reset: hold rst_n=0 with start=1 -> E=0, Code=0, busy=0, done=0. Assert rst_n=0 mid-scan -> E drops to 0 asynchronously, before the next clk edge.
- Full single pass, DWELL=4, BLANK=1, mask=8'hFF, cont=0 -> Code 0..7 in order, each with E=1 for 4 cycles and E=0 for 1 cycle; busy high for 40 cycles; exactly one done pulse, coincident with busy falling.
- Sparse mask 8'b1000_0101, cont=0 -> E-high windows only for Code=0, 2, 7; busy for 15 cycles; done pulses once.
- Continuous mode, mask=8'h81, BLANK=0 -> sequence 0,7,0,7,... with E continuously high; Code changes every 4 cycles; done never pulses over 100 cycles.
- stop asserted while Code=3 -> next cycle E=0, busy=0, Code=3, done=0. A new start with mask=8'h10 then scans only Code=4.
- start with mask=8'h00 -> no response. start while busy with a different mask -> ignored, and the original sequence completes unchanged.

Source files
------------

// File: rtl/decoder_scan_ctrl_if.sv
// Control and output bundle between a scan requester and decoder_scan_ctrl.
// The master side issues start/stop/cont/mask and observes the decoder drive.
interface decoder_scan_ctrl_if;
   logic       start;
   logic       stop;
   logic       cont;
   logic [7:0] mask;
   logic       E;
   logic [2:0] Code;
   logic       busy;
   logic       done;

   modport master (
      output start, stop, cont, mask,
      input  E, Code, busy, done
   );

   modport slave (
      input  start, stop, cont, mask,
      output E, Code, busy, done
   );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer driving a 3-to-8 decoder's enable/select: visits the masked codes in
// ascending order with a programmable dwell and optional blanking gap between codes.
module decoder_scan_ctrl #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned BLANK = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   decoder_scan_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

   localparam bit         HasGap    = (BLANK != 0);
   localparam logic [7:0] DwellLoad = 8'(DWELL - 1);
   localparam logic [7:0] GapLoad   = HasGap ? 8'(BLANK - 1) : 8'd0;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] code_q, code_d;
   logic [7:0] mask_q, mask_d;
   logic       cont_q, cont_d;
   logic       e_q, busy_q, done_q, done_d;

   logic       lo_found, nxt_found;
   logic [2:0] lo_idx, nxt_idx, wrap_idx;
   logic       adv_found;
   logic [2:0] adv_code;

   // Priority search: lowest index overall, and lowest index above the current code.
   always_comb begin
      lo_found  = 1'b0;
      lo_idx    = 3'd0;
      nxt_found = 1'b0;
      nxt_idx   = 3'd0;
      wrap_idx  = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (bus.mask[i]) begin
            lo_found = 1'b1;
            lo_idx   = 3'(i);
         end
         if (mask_q[i]) wrap_idx = 3'(i);
         if (mask_q[i] && (i > int'(code_q))) begin
            nxt_found = 1'b1;
            nxt_idx   = 3'(i);
         end
      end
   end

   assign adv_found = nxt_found || cont_q;
   assign adv_code  = nxt_found ? nxt_idx : wrap_idx;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      mask_d  = mask_q;
      cont_d  = cont_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start && lo_found) begin
               state_d = StActive;
               cnt_d   = DwellLoad;
               code_d  = lo_idx;
               mask_d  = bus.mask;
               cont_d  = bus.cont;
            end
         end
         StActive: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (HasGap) begin
               state_d = StGap;
               cnt_d   = GapLoad;
            end else if (adv_found) begin
               cnt_d  = DwellLoad;
               code_d = adv_code;
            end else begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         StGap: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (adv_found) begin
               state_d = StActive;
               cnt_d   = DwellLoad;
               code_d  = adv_code;
            end else begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      // Abort overrides everything, including a coincident start; Code is held.
      if (bus.stop) begin
         state_d = StIdle;
         cnt_d   = 8'd0;
         code_d  = code_q;
         mask_d  = mask_q;
         cont_d  = cont_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
         code_q  <= 3'd0;
         mask_q  <= 8'd0;
         cont_q  <= 1'b0;
         e_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         mask_q  <= mask_d;
         cont_q  <= cont_d;
         e_q     <= (state_d == StActive);
         busy_q  <= (state_d != StIdle);
         done_q  <= done_d;
      end
   end

   assign bus.E    = e_q;
   assign bus.Code = code_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench: two scanners (with and without blanking) driven by directed and
// random requests; a reference trace is queued per accepted scan and checked each cycle.
module tb_decoder_scan_ctrl;

   localparam int unsigned DWELL  = 4;
   localparam int unsigned BLANK0 = 1;
   localparam int unsigned BLANK1 = 0;

   typedef struct packed {
      logic       e;
      logic [2:0] code;
      logic       busy;
      logic       done;
   } exp_t;

   logic clk;
   logic rst_n;

   decoder_scan_ctrl_if bus0 ();
   decoder_scan_ctrl_if bus1 ();

   decoder_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   decoder_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   exp_t       q0[$];
   exp_t       q1[$];
   logic [2:0] last_code[2];
   logic       last_busy[2];
   bit         cont_active[2];
   int         n_checks;
   int         n_fail;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int qsize(input int u);
      return (u == 0) ? q0.size() : q1.size();
   endfunction

   // Expected per-cycle trace of one accepted scan, straight from the scan rules.
   task automatic gen_trace(input int u, input logic [7:0] m, input bit ct);
      int unsigned bl;
      int          idx[$];
      exp_t        t[$];
      bl = (u == 0) ? BLANK0 : BLANK1;
      for (int i = 0; i < 8; i++) if (m[i]) idx.push_back(i);
      if (idx.size() == 0) return;
      do begin
         foreach (idx[k]) begin
            repeat (DWELL) t.push_back({1'b1, 3'(idx[k]), 1'b1, 1'b0});
            repeat (bl) t.push_back({1'b0, 3'(idx[k]), 1'b1, 1'b0});
         end
      end while (ct && t.size() < 200);
      if (!ct) t.push_back({1'b0, 3'(idx[idx.size()-1]), 1'b0, 1'b1});
      foreach (t[k]) begin
         if (u == 0) q0.push_back(t[k]);
         else q1.push_back(t[k]);
      end
   endtask

   // Drive one cycle of requests (called at a falling edge) and update the model.
   task automatic apply(input int u, input bit st, input bit sp, input bit ct,
                        input logic [7:0] m);
      if (u == 0) begin
         bus0.start = st; bus0.stop = sp; bus0.cont = ct; bus0.mask = m;
      end else begin
         bus1.start = st; bus1.stop = sp; bus1.cont = ct; bus1.mask = m;
      end
      if (sp) begin
         if (u == 0) q0.delete();
         else q1.delete();
         cont_active[u] = 1'b0;
      end else if (st && !last_busy[u] && m != 8'd0) begin
         gen_trace(u, m, ct);
         cont_active[u] = ct;
      end
   endtask

   task automatic idle_inputs();
      apply(0, 1'b0, 1'b0, 1'b0, 8'd0);
      apply(1, 1'b0, 1'b0, 1'b0, 8'd0);
   endtask

   task automatic check_inst(input int u);
      exp_t ex;
      exp_t act;
      if (u == 0) begin
         act = {bus0.E, bus0.Code, bus0.busy, bus0.done};
         ex  = (q0.size() > 0) ? q0.pop_front() : {1'b0, last_code[0], 1'b0, 1'b0};
      end else begin
         act = {bus1.E, bus1.Code, bus1.busy, bus1.done};
         ex  = (q1.size() > 0) ? q1.pop_front() : {1'b0, last_code[1], 1'b0, 1'b0};
      end
      last_code[u] = ex.code;
      last_busy[u] = ex.busy;
      n_checks++;
      if (act !== ex) begin
         n_fail++;
         $display("FAIL scan%0d t=%0t: got E=%b Code=%0d busy=%b done=%b, need E=%b Code=%0d busy=%b done=%b",
                  u, $time, act.e, act.code, act.busy, act.done, ex.e, ex.code, ex.busy, ex.done);
      end
   endtask

   task automatic check_direct(input string name, input logic [5:0] got, input logic [5:0] need);
      n_checks++;
      if (got !== need) begin
         n_fail++;
         $display("FAIL %s t=%0t: got %b, need %b", name, $time, got, need);
      end
   endtask

   // Monitor: compare every cycle, 1 time unit after the rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         check_inst(0);
         check_inst(1);
      end
   end

   initial begin
      bit found;
      n_checks = 0;
      n_fail   = 0;
      for (int u = 0; u < 2; u++) begin
         last_code[u]   = 3'd0;
         last_busy[u]   = 1'b0;
         cont_active[u] = 1'b0;
      end
      rst_n = 1'b0;
      bus0.start = 1'b1; bus0.stop = 1'b0; bus0.cont = 1'b0; bus0.mask = 8'hFF;
      bus1.start = 1'b1; bus1.stop = 1'b0; bus1.cont = 1'b1; bus1.mask = 8'hFF;
      repeat (3) @(negedge clk);
      check_direct("reset_hold0", {bus0.E, bus0.Code, bus0.busy, bus0.done}, 6'd0);
      check_direct("reset_hold1", {bus1.E, bus1.Code, bus1.busy, bus1.done}, 6'd0);
      rst_n = 1'b1;
      idle_inputs();
      @(negedge clk);

      // Full single pass with gaps.
      apply(0, 1'b1, 1'b0, 1'b0, 8'hFF);
      @(negedge clk);
      idle_inputs();
      repeat (45) @(negedge clk);

      // Sparse mask.
      apply(0, 1'b1, 1'b0, 1'b0, 8'b1000_0101);
      @(negedge clk);
      idle_inputs();
      repeat (20) @(negedge clk);

      // Continuous, no blanking, then abort.
      apply(1, 1'b1, 1'b0, 1'b1, 8'h81);
      @(negedge clk);
      idle_inputs();
      repeat (100) @(negedge clk);
      apply(1, 1'b0, 1'b1, 1'b0, 8'd0);
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);

      // Abort on code 3, then a one-code scan.
      apply(0, 1'b1, 1'b0, 1'b0, 8'hFF);
      @(negedge clk);
      idle_inputs();
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (last_code[0] == 3'd3 && last_busy[0]) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL reach_code3: got no busy cycle on code 3, need one within 60 cycles");
      end
      apply(0, 1'b0, 1'b1, 1'b0, 8'd0);
      @(negedge clk);
      idle_inputs();
      repeat (2) @(negedge clk);
      apply(0, 1'b1, 1'b0, 1'b0, 8'h10);
      @(negedge clk);
      idle_inputs();
      repeat (8) @(negedge clk);

      // Empty mask, then start while busy with a different setup.
      apply(0, 1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);
      apply(0, 1'b1, 1'b0, 1'b0, 8'hFF);
      @(negedge clk);
      idle_inputs();
      repeat (5) @(negedge clk);
      apply(0, 1'b1, 1'b0, 1'b1, 8'h0F);
      @(negedge clk);
      idle_inputs();
      repeat (40) @(negedge clk);

      // Asynchronous reset in the middle of a scan, between clock edges.
      apply(0, 1'b1, 1'b0, 1'b0, 8'hFF);
      apply(1, 1'b1, 1'b0, 1'b1, 8'h3C);
      @(negedge clk);
      idle_inputs();
      repeat (9) @(negedge clk);
      #2;
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      for (int u = 0; u < 2; u++) begin
         last_code[u]   = 3'd0;
         last_busy[u]   = 1'b0;
         cont_active[u] = 1'b0;
      end
      #1;
      check_direct("async_reset0", {bus0.E, bus0.Code, bus0.busy, bus0.done}, 6'd0);
      check_direct("async_reset1", {bus1.E, bus1.Code, bus1.busy, bus1.done}, 6'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Random traffic on both scanners.
      for (int c = 0; c < 800; c++) begin
         for (int u = 0; u < 2; u++) begin
            bit         st;
            bit         sp;
            bit         ct;
            logic [7:0] m;
            st = ($urandom_range(0, 5) == 0);
            m  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            ct = ($urandom_range(0, 2) == 0);
            sp = ($urandom_range(0, 79) == 0) || (cont_active[u] && qsize(u) < 20);
            apply(u, st, sp, ct, m);
         end
         @(negedge clk);
      end
      apply(0, 1'b0, 1'b1, 1'b0, 8'd0);
      apply(1, 1'b0, 1'b1, 1'b0, 8'd0);
      @(negedge clk);
      idle_inputs();
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
